// File: rtl/vending_ctrl_param.sv
// vending_ctrl_param
// Parametrised vending/dispense controller. Accumulates coin credit, checks a
// product selection against its price, then runs the product's recipe. Each
// enabled stage is held for STAGE_TICKS cycles. Change is returned at the end.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   coin_100        one-cycle pulse, +1 credit
//   coin_500        one-cycle pulse, +5 credit
//   sel_valid       selection strobe, qualifies sel_id
//   sel_id          selected product index
//   cancel          cancel/refund request
//   credit          current credit
//   stage_en        one-hot active dispense stage, 0 when not dispensing
//   busy            high whenever the controller is not in IDLE
//   dispense_done   one-cycle pulse, product delivered
//   change_valid    one-cycle change strobe
//   change_amt      change value, 0 unless change_valid
//   coin_reject     one-cycle pulse, a coin was returned
//   sel_reject      one-cycle pulse, a selection was refused
//   state_dbg       0 IDLE, 1 DISPENSE, 2 DONE, 3 REFUND
module vending_ctrl_param #(
    parameter int NUM_PRODUCTS = 4,
    parameter int NUM_STAGES   = 5,
    parameter int CREDIT_W     = 8,
    parameter int MAX_CREDIT   = 20,
    parameter int STAGE_TICKS  = 50,
    parameter logic [NUM_PRODUCTS*CREDIT_W-1:0]   PRICES  = {8'd7, 8'd5, 8'd4, 8'd3},
    parameter logic [NUM_PRODUCTS*NUM_STAGES-1:0] RECIPES = {5'b10111, 5'b01001, 5'b00101, 5'b00011}
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            coin_100,
    input  logic                            coin_500,
    input  logic                            sel_valid,
    input  logic [$clog2(NUM_PRODUCTS)-1:0] sel_id,
    input  logic                            cancel,
    output logic [CREDIT_W-1:0]             credit,
    output logic [NUM_STAGES-1:0]           stage_en,
    output logic                            busy,
    output logic                            dispense_done,
    output logic                            change_valid,
    output logic [CREDIT_W-1:0]             change_amt,
    output logic                            coin_reject,
    output logic                            sel_reject,
    output logic [1:0]                      state_dbg
);

    localparam int SEL_W = $clog2(NUM_PRODUCTS);
    localparam int PTR_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
    localparam int TMR_W = $clog2(STAGE_TICKS + 1);
    localparam int SUM_W = CREDIT_W + 1;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DISPENSE = 2'd1,
        DONE     = 2'd2,
        REFUND   = 2'd3
    } state_t;

    state_t              state, state_n;
    logic [CREDIT_W-1:0] credit_n;
    logic [CREDIT_W-1:0] paid, paid_n;
    logic [SEL_W-1:0]    prod, prod_n;
    logic [PTR_W-1:0]    ptr, ptr_n;
    logic [TMR_W-1:0]    timer, timer_n;
    logic                coin_reject_n, sel_reject_n, change_valid_n;
    logic [CREDIT_W-1:0] change_amt_n;

    logic                  sel_in_range;
    logic [SEL_W-1:0]      sel_idx;
    logic [CREDIT_W-1:0]   sel_price;
    logic [NUM_STAGES-1:0] sel_recipe;
    logic [NUM_STAGES-1:0] cur_recipe;
    logic                  next_found;
    logic [PTR_W-1:0]      next_ptr;
    logic [SUM_W-1:0]      coin_sum;

    // Index of the lowest set bit of a recipe mask (0 for an empty mask).
    function automatic logic [PTR_W-1:0] lowest_bit(input logic [NUM_STAGES-1:0] m);
        logic [PTR_W-1:0] r;
        r = '0;
        for (int i = NUM_STAGES - 1; i >= 0; i--) begin
            if (m[i]) r = PTR_W'(i);
        end
        return r;
    endfunction

    // Out-of-range ids are redirected to product 0 so the table part-select
    // never leaves the packed vector; the refusal uses sel_in_range.
    always_comb begin
        sel_in_range = (int'(sel_id) < NUM_PRODUCTS);
        sel_idx      = sel_in_range ? sel_id : '0;
        sel_price    = PRICES[int'(sel_idx)*CREDIT_W +: CREDIT_W];
        sel_recipe   = RECIPES[int'(sel_idx)*NUM_STAGES +: NUM_STAGES];
        cur_recipe   = RECIPES[int'(prod)*NUM_STAGES +: NUM_STAGES];
    end

    // Next enabled stage above the current one. Scanning downwards leaves the
    // nearest higher bit as the final winner.
    always_comb begin
        next_found = 1'b0;
        next_ptr   = ptr;
        for (int i = NUM_STAGES - 1; i >= 0; i--) begin
            if (cur_recipe[i] && (i > int'(ptr))) begin
                next_found = 1'b1;
                next_ptr   = PTR_W'(i);
            end
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            credit       <= '0;
            paid         <= '0;
            prod         <= '0;
            ptr          <= '0;
            timer        <= '0;
            coin_reject  <= 1'b0;
            sel_reject   <= 1'b0;
            change_valid <= 1'b0;
            change_amt   <= '0;
        end else begin
            state        <= state_n;
            credit       <= credit_n;
            paid         <= paid_n;
            prod         <= prod_n;
            ptr          <= ptr_n;
            timer        <= timer_n;
            coin_reject  <= coin_reject_n;
            sel_reject   <= sel_reject_n;
            change_valid <= change_valid_n;
            change_amt   <= change_amt_n;
        end
    end

    // Next-state and datapath update.
    always_comb begin
        state_n        = state;
        credit_n       = credit;
        paid_n         = paid;
        prod_n         = prod;
        ptr_n          = ptr;
        timer_n        = timer;
        coin_reject_n  = 1'b0;
        sel_reject_n   = 1'b0;
        change_valid_n = 1'b0;
        change_amt_n   = '0;
        coin_sum       = {1'b0, credit};

        unique case (state)
            IDLE: begin
                if (cancel && (credit != '0)) begin
                    coin_reject_n = coin_100 | coin_500;
                    state_n       = REFUND;
                end else if (sel_valid) begin
                    coin_reject_n = coin_100 | coin_500;
                    if (!sel_in_range || (sel_recipe == '0) || (sel_price > credit)) begin
                        sel_reject_n = 1'b1;
                    end else begin
                        credit_n = credit - sel_price;
                        paid_n   = sel_price;
                        prod_n   = sel_idx;
                        ptr_n    = lowest_bit(sel_recipe);
                        timer_n  = '0;
                        state_n  = DISPENSE;
                    end
                end else begin
                    // coin_100 is judged against the sum after coin_500.
                    if (coin_500) begin
                        if (coin_sum + SUM_W'(5) <= SUM_W'(MAX_CREDIT)) coin_sum = coin_sum + SUM_W'(5);
                        else coin_reject_n = 1'b1;
                    end
                    if (coin_100) begin
                        if (coin_sum + SUM_W'(1) <= SUM_W'(MAX_CREDIT)) coin_sum = coin_sum + SUM_W'(1);
                        else coin_reject_n = 1'b1;
                    end
                    credit_n = coin_sum[CREDIT_W-1:0];
                end
            end

            DISPENSE: begin
                coin_reject_n = coin_100 | coin_500;
                // Abort is only honoured while the first stage is running.
                if (cancel && (ptr == lowest_bit(cur_recipe))) begin
                    credit_n = credit + paid;
                    state_n  = REFUND;
                end else if (timer == TMR_W'(STAGE_TICKS - 1)) begin
                    timer_n = '0;
                    if (next_found) ptr_n = next_ptr;
                    else state_n = DONE;
                end else begin
                    timer_n = timer + TMR_W'(1);
                end
            end

            DONE, REFUND: begin
                coin_reject_n  = coin_100 | coin_500;
                change_valid_n = 1'b1;
                change_amt_n   = credit;
                credit_n       = '0;
                state_n        = IDLE;
            end

            default: state_n = IDLE;
        endcase
    end

    // Outputs decoded from the registered state.
    always_comb begin
        stage_en      = (state == DISPENSE) ? (NUM_STAGES'(1) << ptr) : '0;
        busy          = (state != IDLE);
        dispense_done = (state == DONE);
        state_dbg     = state;
    end

endmodule

// File: tb/tb_vending_ctrl_param.sv
// tb_vending_ctrl_param
// Scoreboard bench for vending_ctrl_param with STAGE_TICKS=4. Expected stage
// cycles and change amounts are queued when a transaction is started. A
// monitor pops and compares them as the DUT produces stage_en / change_valid.
module tb_vending_ctrl_param;

    localparam int ST = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       coin_100 = 1'b0;
    logic       coin_500 = 1'b0;
    logic       sel_valid = 1'b0;
    logic [1:0] sel_id = 2'd0;
    logic       cancel = 1'b0;
    logic [7:0] credit;
    logic [4:0] stage_en;
    logic       busy;
    logic       dispense_done;
    logic       change_valid;
    logic [7:0] change_amt;
    logic       coin_reject;
    logic       sel_reject;
    logic [1:0] state_dbg;

    int checks = 0;
    int errors = 0;

    logic [31:0] stage_q[$];
    logic [31:0] change_q[$];
    logic [31:0] mon_exp;

    // Reference recipe masks, product 0 first.
    logic [4:0] recipe_tbl[4] = '{5'b00011, 5'b00101, 5'b01001, 5'b10111};

    vending_ctrl_param #(.STAGE_TICKS(ST)) dut (
        .clk(clk), .rst(rst), .coin_100(coin_100), .coin_500(coin_500),
        .sel_valid(sel_valid), .sel_id(sel_id), .cancel(cancel),
        .credit(credit), .stage_en(stage_en), .busy(busy),
        .dispense_done(dispense_done), .change_valid(change_valid),
        .change_amt(change_amt), .coin_reject(coin_reject),
        .sel_reject(sel_reject), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
        end
    endtask

    // Drive one cycle of inputs, let the active edge take them, then release.
    task automatic applyStimulus(input logic c100, input logic c500, input logic sv,
                                 input logic [1:0] sid, input logic cn);
        coin_100 = c100; coin_500 = c500; sel_valid = sv; sel_id = sid; cancel = cn;
        @(posedge clk); #1;
        coin_100 = 1'b0; coin_500 = 1'b0; sel_valid = 1'b0; sel_id = 2'd0; cancel = 1'b0;
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic pushStages(input logic [4:0] mask);
        for (int b = 0; b < 5; b++)
            if (mask[b])
                for (int t = 0; t < ST; t++) stage_q.push_back(32'd1 << b);
    endtask

    task automatic waitIdle();
        int n;
        n = 0;
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        checkOutput("idle_timeout", {31'd0, busy}, 32'd0);
        @(posedge clk); #1;
        checkOutput("credit_after_change", credit, 32'd0);
    endtask

    // Scoreboard monitor, sampling on the inactive edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (stage_en != 5'd0) begin
                if (stage_q.size() == 0) checkOutput("stage_unexpected", stage_en, 32'd0);
                else begin
                    mon_exp = stage_q.pop_front();
                    checkOutput("stage_en", stage_en, mon_exp);
                end
            end
            if (dispense_done) checkOutput("done_stages_left", stage_q.size(), 32'd0);
            if (change_valid) begin
                if (change_q.size() == 0) checkOutput("change_unexpected", 32'd1, 32'd0);
                else begin
                    mon_exp = change_q.pop_front();
                    checkOutput("change_amt", change_amt, mon_exp);
                end
            end
        end
    end

    initial begin
        // Reset state
        idleCycles(2);
        checkOutput("rst_credit", credit, 32'd0);
        checkOutput("rst_busy", {31'd0, busy}, 32'd0);
        checkOutput("rst_stage", stage_en, 32'd0);
        checkOutput("rst_state", state_dbg, 32'd0);
        rst = 1'b0;
        idleCycles(1);

        // Selection with change: 6 credit, product 1 (price 4)
        applyStimulus(0, 1, 0, 2'd0, 0);
        checkOutput("coin500_credit", credit, 32'd5);
        applyStimulus(1, 0, 0, 2'd0, 0);
        checkOutput("coin100_credit", credit, 32'd6);
        pushStages(recipe_tbl[1]);
        change_q.push_back(32'd2);
        applyStimulus(0, 0, 1, 2'd1, 0);
        checkOutput("sel1_credit", credit, 32'd2);
        checkOutput("sel1_busy", {31'd0, busy}, 32'd1);
        waitIdle();

        // Reset in the middle of a dispense
        applyStimulus(0, 1, 0, 2'd0, 0);
        pushStages(recipe_tbl[0]);
        applyStimulus(0, 0, 1, 2'd0, 0);
        idleCycles(2);
        #1 rst = 1'b1;
        #1;
        checkOutput("midrst_stage", stage_en, 32'd0);
        checkOutput("midrst_busy", {31'd0, busy}, 32'd0);
        checkOutput("midrst_state", state_dbg, 32'd0);
        checkOutput("midrst_credit", credit, 32'd0);
        checkOutput("midrst_change", {31'd0, change_valid}, 32'd0);
        stage_q.delete();
        change_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        idleCycles(1);

        // Insufficient credit, then an affordable product with zero change
        for (int i = 0; i < 3; i++) applyStimulus(1, 0, 0, 2'd0, 0);
        applyStimulus(0, 0, 1, 2'd3, 0);
        checkOutput("insuff_sel_reject", {31'd0, sel_reject}, 32'd1);
        checkOutput("insuff_credit", credit, 32'd3);
        checkOutput("insuff_busy", {31'd0, busy}, 32'd0);
        pushStages(recipe_tbl[0]);
        change_q.push_back(32'd0);
        applyStimulus(0, 0, 1, 2'd0, 0);
        checkOutput("sel0_sel_reject", {31'd0, sel_reject}, 32'd0);
        checkOutput("sel0_credit", credit, 32'd0);
        waitIdle();

        // Overflow guard at 18
        for (int i = 0; i < 3; i++) applyStimulus(0, 1, 0, 2'd0, 0);
        for (int i = 0; i < 3; i++) applyStimulus(1, 0, 0, 2'd0, 0);
        checkOutput("build18", credit, 32'd18);
        applyStimulus(0, 1, 0, 2'd0, 0);
        checkOutput("ovf500_reject", {31'd0, coin_reject}, 32'd1);
        checkOutput("ovf500_credit", credit, 32'd18);
        applyStimulus(1, 0, 0, 2'd0, 0);
        checkOutput("ovf100_reject", {31'd0, coin_reject}, 32'd0);
        checkOutput("ovf100_credit", credit, 32'd19);
        change_q.push_back(32'd19);
        applyStimulus(0, 0, 0, 2'd0, 1);
        waitIdle();

        // Both coins at 14: 500 then 100 lands exactly on 20
        for (int i = 0; i < 2; i++) applyStimulus(0, 1, 0, 2'd0, 0);
        for (int i = 0; i < 4; i++) applyStimulus(1, 0, 0, 2'd0, 0);
        applyStimulus(1, 1, 0, 2'd0, 0);
        checkOutput("both14_credit", credit, 32'd20);
        checkOutput("both14_reject", {31'd0, coin_reject}, 32'd0);
        change_q.push_back(32'd20);
        applyStimulus(0, 0, 0, 2'd0, 1);
        waitIdle();

        // Both coins at 15: 500 fits, 100 would overflow
        for (int i = 0; i < 3; i++) applyStimulus(0, 1, 0, 2'd0, 0);
        applyStimulus(1, 1, 0, 2'd0, 0);
        checkOutput("both15_credit", credit, 32'd20);
        checkOutput("both15_reject", {31'd0, coin_reject}, 32'd1);
        change_q.push_back(32'd20);
        applyStimulus(0, 0, 0, 2'd0, 1);
        waitIdle();

        // Abort in the first stage refunds the price
        applyStimulus(0, 1, 0, 2'd0, 0);
        applyStimulus(0, 1, 0, 2'd0, 0);
        stage_q.push_back(32'd1);
        stage_q.push_back(32'd1);
        change_q.push_back(32'd10);
        applyStimulus(0, 0, 1, 2'd3, 0);
        checkOutput("sel3_credit", credit, 32'd3);
        idleCycles(1);
        applyStimulus(0, 0, 0, 2'd0, 1);
        checkOutput("abort_credit", credit, 32'd10);
        checkOutput("abort_state", state_dbg, 32'd3);
        waitIdle();

        // Cancel in the coffee stage is ignored; coins and selections refused
        applyStimulus(0, 1, 0, 2'd0, 0);
        applyStimulus(0, 1, 0, 2'd0, 0);
        pushStages(recipe_tbl[3]);
        change_q.push_back(32'd3);
        applyStimulus(0, 0, 1, 2'd3, 0);
        idleCycles(5);
        applyStimulus(0, 0, 0, 2'd0, 1);
        checkOutput("late_cancel_state", state_dbg, 32'd1);
        applyStimulus(1, 0, 0, 2'd0, 0);
        checkOutput("busy_coin_reject", {31'd0, coin_reject}, 32'd1);
        checkOutput("busy_coin_credit", credit, 32'd3);
        applyStimulus(0, 0, 1, 2'd0, 0);
        checkOutput("busy_sel_reject", {31'd0, sel_reject}, 32'd0);
        checkOutput("busy_sel_state", state_dbg, 32'd1);
        waitIdle();

        // Cancel with zero credit produces nothing
        applyStimulus(0, 0, 0, 2'd0, 1);
        checkOutput("cancel0_state", state_dbg, 32'd0);
        idleCycles(3);

        // Cancel and coin in the same cycle at credit 4
        for (int i = 0; i < 4; i++) applyStimulus(1, 0, 0, 2'd0, 0);
        change_q.push_back(32'd4);
        applyStimulus(1, 0, 0, 2'd0, 1);
        checkOutput("cancel_coin_reject", {31'd0, coin_reject}, 32'd1);
        checkOutput("cancel_coin_state", state_dbg, 32'd3);
        checkOutput("cancel_coin_credit", credit, 32'd4);
        waitIdle();

        idleCycles(2);
        checkOutput("stage_q_drained", stage_q.size(), 32'd0);
        checkOutput("change_q_drained", change_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
